cordic_arb: RTL

CORDIC_ARB -- requirements
Module: cordic_arb

---
 rtl/cordic_arb_if.sv | 26 ++
 rtl/cordic_arb.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cordic_arb_if.sv
// Request/response bus between the requesters, their result consumer and cordic_arb.
// Latency: none, plain wiring.
// Backpressure: req_ready is a one-hot accept pulse; rsp_valid is held until rsp_ready.
interface cordic_arb_if;
  logic [3:0]  req_valid;
  logic [63:0] req_angle;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_v0;
  logic [15:0] rsp_v1;
  logic        rsp_err;

  // Requester / consumer side
  modport master (
    output req_valid, req_angle, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_v0, rsp_v1, rsp_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_angle, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_v0, rsp_v1, rsp_err
  );
endinterface

// File: rtl/cordic_arb.sv
// Round-robin arbiter sharing one CORDIC rotator core among 4 requesters (optional watchdog: CORDIC_ARB_TIMEOUT_EN).
// Latency: grant -> core_start 1 cycle; rsp_valid 1 cycle after the core reports done.
// Backpressure: one operation in flight; no grant while a response waits on rsp_ready.
module cordic_arb #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic        clk,
  input  logic        reset,
  cordic_arb_if.slave host,
  output logic        core_start,
  output logic [15:0] core_angle,
  input  logic        core_ready,
  input  logic [15:0] core_v0,
  input  logic [15:0] core_v1,
  output logic        core_reset
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  last_grant;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic        grant_any;
  logic [15:0] grant_angle;
  logic [1:0]  rsp_id_q;
  logic [15:0] angle_q;
  logic [15:0] v0_q;
  logic [15:0] v1_q;
  logic        timeout;
  logic        rsp_hs;

  // Round-robin search: first valid requester above last_grant, wrapping mod 4
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_any && host.req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_angle = host.req_angle[{grant_idx, 4'b0000} +: 16];
  assign rsp_hs      = host.rsp_valid & host.rsp_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant_any) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout)          state_nxt = RESP;
        else if (!core_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout || core_ready) state_nxt = RESP;
      end
      RESP:      if (rsp_hs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the granted angle/id, capture core results, rotate priority on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 2'd3;
      rsp_id_q   <= 2'd0;
      angle_q    <= 16'd0;
      v0_q       <= 16'd0;
      v1_q       <= 16'd0;
    end else begin
      if (state == IDLE && grant_any) begin
        rsp_id_q <= grant_idx;
        angle_q  <= grant_angle;
      end
      if (timeout) begin
        v0_q <= 16'd0;
        v1_q <= 16'd0;
      end else if (state == WAIT_DONE && core_ready) begin
        v0_q <= core_v0;
        v1_q <= core_v1;
      end
      if (state == RESP && rsp_hs) last_grant <= rsp_id_q;
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wdog;
  logic        err_q;
  logic        core_rst_q;
  logic        in_wait;

  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timeout = in_wait && (wdog == WDOG_LIM);

  // Watchdog: counts waiting cycles, clears when heading to RESP; timeout kicks the core
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog       <= 16'd0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      wdog       <= (in_wait && state_nxt != RESP) ? wdog + 16'd1 : 16'd0;
      core_rst_q <= timeout;
      if (timeout)                               err_q <= 1'b1;
      else if (state == WAIT_DONE && core_ready) err_q <= 1'b0;
    end
  end

  assign host.rsp_err = err_q;
  assign core_reset   = reset | core_rst_q;
`else
  assign timeout      = 1'b0;
  assign host.rsp_err = 1'b0;
  assign core_reset   = reset;
`endif

  // Reset gates req_ready because the accept pulse is combinational in IDLE
  assign host.req_ready = (state == IDLE && grant_any && !reset) ? (4'b0001 << grant_idx) : 4'b0000;
  assign host.rsp_valid = (state == RESP);
  assign host.rsp_id    = rsp_id_q;
  assign host.rsp_v0    = v0_q;
  assign host.rsp_v1    = v1_q;
  assign core_start     = (state == LAUNCH);
  assign core_angle     = angle_q;

endmodule
